act_pwl_unit: RTL and testbench
===============================

# act_pwl_unit

Multi-lane, pipelined piecewise-linear activation unit that applies y = a·x + b per lane, with (a, b) fetched from a runtime-loadable coefficient LUT indexed by the upper bits of x. It sits between the neuron-unit accumulators and the XY memory write-back. It generalises the fixed activation settings to a parametrised lane count, fixed-point format and LUT depth. It adds two selectable coefficient banks, identity/ReLU modes, valid/ready backpressure and saturation reporting.

## Interface
- NU_COUNT, 4, number of parallel lanes
- Q_INT, 4, integer bits of data (signed, includes sign)
- Q_FRAC, 12, fractional bits of data; Q_SIZE = Q_INT + Q_FRAC
- ACT_LUT_DEPTH, 6, log2 segments per bank
- ACT_A_Q_INT / ACT_A_Q_FRAC, 4 / 12, slope format; ACT_A_COEF_SIZE = sum
- ACT_B_Q_INT / ACT_B_Q_FRAC, 4 / 12, offset format; ACT_B_Q_FRAC must equal Q_FRAC (elaboration-time check)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  unit accepts beat this cycle
- in_mode  in  2  per-beat mode: 00 identity, 01 ReLU, 10 PWL bank 0, 11 PWL bank 1
- in_data  in  NU_COUNT*Q_SIZE  lane i at [i*Q_SIZE +: Q_SIZE], signed
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  NU_COUNT*Q_SIZE  results, same packing
- out_sat  out  NU_COUNT  per-lane saturation flag for this beat
- lut_we  in  1  coefficient write strobe
- lut_addr  in  1+ACT_LUT_DEPTH  {bank, index}
- lut_wdata  in  ACT_A_COEF_SIZE+ACT_B_COEF_SIZE  {a, b}, a in upper bits

## Operation
- LUT: 2 banks × 2^ACT_LUT_DEPTH entries, replicated per lane (one read port per lane); writes broadcast to all replicas. Contents are not reset.
- Segment index = {~x[Q_SIZE-1], x[Q_SIZE-2 -: ACT_LUT_DEPTH-1]} (offset binary): most negative x → index 0, x = 0 → index 2^(ACT_LUT_DEPTH-1).
- Stage 1: register x and mode, and issue a synchronous LUT read at {mode[0], index}.
- Stage 2: p = a·x, signed full width Q_SIZE+ACT_A_COEF_SIZE. Arithmetic shift right by ACT_A_Q_FRAC (truncate toward −inf).
- Stage 3: s = p_shifted + sign-extended b, then saturate to signed Q_SIZE. Set out_sat when clamped.
- Identity mode: y = x. ReLU mode: y = (x<0) ? 0 : x. In both modes out_sat = 0 and LUT data is ignored.
- Pipeline is a single global-stall pipeline: stall = out_valid & ~out_ready. in_ready = ~stall. When stalled, all stages hold.
- Reset clears all valid bits, out_data = 0, out_sat = 0. Reset mid-stream drops in-flight beats, and in_ready = 1 the cycle after reset deasserts.

## Timing
- Latency 3 cycles: a beat accepted at edge N appears with out_valid at edge N+3 when there is no stall. Throughput is 1 beat/cycle.
- out_data/out_sat stay stable while out_valid & ~out_ready.
- A LUT write at edge N is visible to stage-1 reads at edge N+1 or later. A same-cycle read of the written address returns the old entry.
- LUT writes are accepted regardless of stall or in_valid. A beat already past stage 1 keeps its fetched coefficients.
- in_mode is sampled with its beat, so mode changes between consecutive beats are legal.

## Test plan
- Identity/ReLU: lanes {0x1800, 0xF000, 0x0000, 0x7FFF}, mode 00 → same values at +3 cycles. Mode 01 → {0x1800, 0x0000, 0x0000, 0x7FFF}, out_sat = 0.
- PWL basic: fill bank 0 with a = 0x0800, b = 0x0400. x = 0x2000 → 0x1400 (1.25). x = 0xF000 → 0xFC00 (−0.25).
- Indexing/banks: bank 0 entry k = {a=0, b=k<<4}, bank 1 entry k = {a=0, b=0x0100+k}. x = 0x8000, 0x0000, 0x7FFF in mode 10 → 0x0000, 0x0200, 0x03F0. The same x values in mode 11 → 0x0100, 0x0120, 0x013F.
- Saturation: a = 0x7FFF, b = 0. x = 0x4000 → 0x7FFF with sat = 1. x = 0xC000 → 0x8000 with sat = 1.
- Backpressure: stream 8 beats with out_ready toggling 1,0,0,1,… → in_ready low exactly while stalled, all 8 results delivered in order with no duplicates.
- Write hazard/reset: write an entry on the same cycle a beat reads it → the beat gets the old value and the next beat gets the new one. Assert rst with 3 beats in flight → out_valid = 0 and out_data = 0 after the reset edge, and none of the in-flight beats emerge afterwards.

Source files
------------

// File: rtl/act_pwl_unit.sv
// ---------------------------------------------------------------------------
// act_pwl_unit
//
// Multi-lane pipelined piecewise-linear activation unit. Each lane computes
// y = a*x + b, where (a, b) are fetched from a runtime-loadable coefficient
// LUT indexed by the upper bits of x. Identity and ReLU modes bypass the LUT.
// The unit sits between the neuron-unit accumulators and XY memory write-back.
//
// Pipeline (single global stall, latency 3 from accept edge to out_valid):
//   accept edge : register x/mode, synchronous LUT read of (a, b)
//   +1          : p = (a*x) >>> ACT_A_Q_FRAC
//   +2          : s = p + sign-extended b
//   +3          : mode select and saturation into the output register
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input beat valid
//   in_ready   unit accepts a beat this cycle
//   in_mode    00 identity, 01 ReLU, 10 PWL bank 0, 11 PWL bank 1
//   in_data    NU_COUNT signed lanes, lane i at [i*Q_SIZE +: Q_SIZE]
//   out_valid  output beat valid
//   out_ready  downstream accepts the output beat
//   out_data   NU_COUNT results, same packing as in_data
//   out_sat    per-lane flag, set when the PWL result was clamped
//   lut_we     coefficient write strobe
//   lut_addr   {bank, index}
//   lut_wdata  {a, b}, a in the upper bits
// ---------------------------------------------------------------------------
module act_pwl_unit #(
    parameter int NU_COUNT      = 4,
    parameter int Q_INT         = 4,
    parameter int Q_FRAC        = 12,
    parameter int ACT_LUT_DEPTH = 6,
    parameter int ACT_A_Q_INT   = 4,
    parameter int ACT_A_Q_FRAC  = 12,
    parameter int ACT_B_Q_INT   = 4,
    parameter int ACT_B_Q_FRAC  = 12,
    localparam int Q_SIZE          = Q_INT + Q_FRAC,
    localparam int ACT_A_COEF_SIZE = ACT_A_Q_INT + ACT_A_Q_FRAC,
    localparam int ACT_B_COEF_SIZE = ACT_B_Q_INT + ACT_B_Q_FRAC
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [1:0]                                 in_mode,
    input  logic [NU_COUNT*Q_SIZE-1:0]                 in_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [NU_COUNT*Q_SIZE-1:0]                 out_data,
    output logic [NU_COUNT-1:0]                        out_sat,
    input  logic                                       lut_we,
    input  logic [ACT_LUT_DEPTH:0]                     lut_addr,
    input  logic [ACT_A_COEF_SIZE+ACT_B_COEF_SIZE-1:0] lut_wdata
);

    localparam int P_W         = Q_SIZE + ACT_A_COEF_SIZE;
    localparam int COEF_W      = ACT_A_COEF_SIZE + ACT_B_COEF_SIZE;
    localparam int LUT_ENTRIES = 2 ** (ACT_LUT_DEPTH + 1);

    // b is added to the shifted product without realignment, so both must
    // share the data fractional width.
    generate
        if (ACT_B_Q_FRAC != Q_FRAC) begin : g_bFracMismatch
            $error("act_pwl_unit: ACT_B_Q_FRAC must equal Q_FRAC");
        end
    endgenerate

    logic       w_stall;
    logic       r1_valid, r2_valid, r3_valid;
    logic [1:0] r1_mode, r2_mode, r3_mode;

    // A held output beat freezes every stage at once.
    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall;

    // Valid and mode travel alongside the lane data through all stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid  <= 1'b0;
            r2_valid  <= 1'b0;
            r3_valid  <= 1'b0;
            out_valid <= 1'b0;
            r1_mode   <= 2'b00;
            r2_mode   <= 2'b00;
            r3_mode   <= 2'b00;
        end else if (!w_stall) begin
            r1_valid  <= in_valid;
            r2_valid  <= r1_valid;
            r3_valid  <= r2_valid;
            out_valid <= r3_valid;
            r1_mode   <= in_mode;
            r2_mode   <= r1_mode;
            r3_mode   <= r2_mode;
        end
    end

    for (genvar i = 0; i < NU_COUNT; i++) begin : g_lane
        logic        [COEF_W-1:0]          r_lut [LUT_ENTRIES];
        logic        [Q_SIZE-1:0]          w_x;
        logic        [ACT_LUT_DEPTH-1:0]   w_idx;
        logic        [COEF_W-1:0]          r_coef;
        logic signed [Q_SIZE-1:0]          r1_x, r2_x, r3_x;
        logic signed [ACT_A_COEF_SIZE-1:0] w_a;
        logic signed [P_W-1:0]             w_aExt, w_xExt, w_prod, w_pShift;
        logic signed [P_W-1:0]             r2_p, w_bExt, r3_s;
        logic        [ACT_B_COEF_SIZE-1:0] r2_b;
        logic        [P_W-Q_SIZE:0]        w_hi;
        logic                              w_ovf;
        logic        [Q_SIZE-1:0]          w_y, r_y;
        logic                              w_sat, r_sat;

        // Offset-binary segment index: most negative x maps to entry 0.
        assign w_x   = in_data[i*Q_SIZE +: Q_SIZE];
        assign w_idx = {~w_x[Q_SIZE-1], w_x[Q_SIZE-2 -: ACT_LUT_DEPTH-1]};

        // Every lane keeps its own replica so each has a private read port;
        // writes are broadcast and ignore the pipeline stall.
        always_ff @(posedge clk) begin
            if (lut_we) begin
                r_lut[lut_addr] <= lut_wdata;
            end
        end

        // Stage 1: a write on this same edge is not yet seen by this read.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_coef <= '0;
                r1_x   <= '0;
            end else if (!w_stall) begin
                r_coef <= r_lut[{in_mode[0], w_idx}];
                r1_x   <= w_x;
            end
        end

        assign w_a      = r_coef[COEF_W-1 -: ACT_A_COEF_SIZE];
        assign w_aExt   = {{(P_W-ACT_A_COEF_SIZE){w_a[ACT_A_COEF_SIZE-1]}}, w_a};
        assign w_xExt   = {{(P_W-Q_SIZE){r1_x[Q_SIZE-1]}}, r1_x};
        assign w_prod   = w_aExt * w_xExt;
        assign w_pShift = w_prod >>> ACT_A_Q_FRAC;

        // Stage 2: full-width product, arithmetic shift floors toward -inf.
        always_ff @(posedge clk) begin
            if (rst) begin
                r2_p <= '0;
                r2_b <= '0;
                r2_x <= '0;
            end else if (!w_stall) begin
                r2_p <= w_pShift;
                r2_b <= r_coef[ACT_B_COEF_SIZE-1:0];
                r2_x <= r1_x;
            end
        end

        assign w_bExt = {{(P_W-ACT_B_COEF_SIZE){r2_b[ACT_B_COEF_SIZE-1]}}, r2_b};

        // Stage 3: unsaturated sum, wide enough that it cannot overflow.
        always_ff @(posedge clk) begin
            if (rst) begin
                r3_s <= '0;
                r3_x <= '0;
            end else if (!w_stall) begin
                r3_s <= r2_p + w_bExt;
                r3_x <= r2_x;
            end
        end

        // The sum fits in Q_SIZE only if all bits from the Q_SIZE sign bit
        // upward agree.
        assign w_hi  = r3_s[P_W-1:Q_SIZE-1];
        assign w_ovf = ~((&w_hi) | ~(|w_hi));

        always_comb begin
            w_y   = r3_x;
            w_sat = 1'b0;
            case (r3_mode)
                2'b00: w_y = r3_x;
                2'b01: begin
                    if (r3_x[Q_SIZE-1]) begin
                        w_y = '0;
                    end
                end
                default: begin
                    if (w_ovf) begin
                        w_y   = r3_s[P_W-1] ? {1'b1, {(Q_SIZE-1){1'b0}}}
                                            : {1'b0, {(Q_SIZE-1){1'b1}}};
                        w_sat = r3_valid;
                    end else begin
                        w_y = r3_s[Q_SIZE-1:0];
                    end
                end
            endcase
        end

        // Output register holds its value while downstream stalls.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_y   <= '0;
                r_sat <= 1'b0;
            end else if (!w_stall) begin
                r_y   <= w_y;
                r_sat <= w_sat;
            end
        end

        assign out_data[i*Q_SIZE +: Q_SIZE] = r_y;
        assign out_sat[i]                   = r_sat;
    end

endmodule

// File: tb/tb_act_pwl_unit.sv
// ---------------------------------------------------------------------------
// tb_act_pwl_unit
//
// Self-checking bench for act_pwl_unit. A table of single-beat vectors
// (identity, ReLU, PWL, bank indexing, saturation) is applied one beat at a
// time with its LUT contents loaded first; hand-written sequences cover
// backpressure, the LUT write/read hazard and reset with beats in flight.
// ---------------------------------------------------------------------------
module tb_act_pwl_unit;

    localparam int NU = 4;
    localparam int QS = 16;
    localparam int DW = NU * QS;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_mode;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [NU-1:0] out_sat;
    logic          lut_we;
    logic [6:0]    lut_addr;
    logic [31:0]   lut_wdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string         name;
        int            setup;
        logic [1:0]    mode;
        logic [DW-1:0] data;
        logic [DW-1:0] expData;
        logic [NU-1:0] expSat;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    act_pwl_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .lut_we    (lut_we),
        .lut_addr  (lut_addr),
        .lut_wdata (lut_wdata)
    );

    function automatic logic [DW-1:0] pack4(input logic [15:0] l0, input logic [15:0] l1,
                                            input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [DW-1:0] beatData(input int k);
        logic [DW-1:0] d;
        for (int l = 0; l < NU; l++) begin
            d[l*QS +: QS] = 16'h1000 + 16'(k * 16 + l);
        end
        return d;
    endfunction

    task automatic addVec(input string name, input int setup, input logic [1:0] mode,
                          input logic [DW-1:0] data, input logic [DW-1:0] expData,
                          input logic [NU-1:0] expSat);
        vec_t v;
        v.name    = name;
        v.setup   = setup;
        v.mode    = mode;
        v.data    = data;
        v.expData = expData;
        v.expSat  = expSat;
        vecs.push_back(v);
    endtask

    task automatic checkValue(input string name, input logic [DW-1:0] actual,
                              input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic writeLut(input logic bank, input int idx, input logic [15:0] a,
                            input logic [15:0] b);
        lut_we    = 1'b1;
        lut_addr  = {bank, 6'(idx)};
        lut_wdata = {a, b};
        @(posedge clk);
        #1;
        lut_we = 1'b0;
    endtask

    task automatic loadSetup(input int setup);
        for (int k = 0; k < 64; k++) begin
            case (setup)
                1: writeLut(1'b0, k, 16'h0800, 16'h0400);
                2: begin
                    writeLut(1'b0, k, 16'h0000, 16'(k << 4));
                    writeLut(1'b1, k, 16'h0000, 16'(16'h0100 + k));
                end
                3: writeLut(1'b0, k, 16'h7FFF, 16'h0000);
                default: ;
            endcase
        end
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic [DW-1:0] data);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mode  = 2'b00;
    endtask

    // Waits a bounded number of cycles for out_valid, checks how many edges
    // it took, then the data and saturation flags, and consumes the beat.
    task automatic checkOutput(input string name, input logic [DW-1:0] expData,
                               input logic [NU-1:0] expSat, input int expWait);
        int waited = 0;
        while (!out_valid && waited < 12) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checks++;
        if (!out_valid) begin
            failures++;
            $display("[TB] FAIL %s arrival: got no out_valid after %0d cycles, expected one after %0d",
                     name, waited, expWait);
        end else begin
            checkValue({name, " latency"}, 64'(waited), 64'(expWait));
            checkValue({name, " data"}, out_data, expData);
            checkValue({name, " sat"}, 64'(out_sat), 64'(expSat));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] qExp[$];
        logic [3:0]    mV;
        logic          mStall;
        logic          accept;
        int            curSetup;
        int            sent;
        int            rcvd;
        int            seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 2'b00;
        in_data   = '0;
        out_ready = 1'b1;
        lut_we    = 1'b0;
        lut_addr  = '0;
        lut_wdata = '0;

        // Vector table: {name, LUT setup, mode, lanes in, lanes expected, sat}
        addVec("identity", 0, 2'b00, pack4(16'h1800, 16'hF000, 16'h0000, 16'h7FFF),
               pack4(16'h1800, 16'hF000, 16'h0000, 16'h7FFF), 4'b0000);
        addVec("relu", 0, 2'b01, pack4(16'h1800, 16'hF000, 16'h0000, 16'h7FFF),
               pack4(16'h1800, 16'h0000, 16'h0000, 16'h7FFF), 4'b0000);
        addVec("pwlBasic", 1, 2'b10, pack4(16'h2000, 16'hF000, 16'h0000, 16'h8000),
               pack4(16'h1400, 16'hFC00, 16'h0400, 16'hC400), 4'b0000);
        addVec("pwlFloor", 1, 2'b10, pack4(16'hFFFF, 16'h0001, 16'h2000, 16'hF000),
               pack4(16'h03FF, 16'h0400, 16'h1400, 16'hFC00), 4'b0000);
        addVec("idxBank0", 2, 2'b10, pack4(16'h8000, 16'h0000, 16'h7FFF, 16'hFFFF),
               pack4(16'h0000, 16'h0200, 16'h03F0, 16'h01F0), 4'b0000);
        addVec("idxBank1", 2, 2'b11, pack4(16'h8000, 16'h0000, 16'h7FFF, 16'hFFFF),
               pack4(16'h0100, 16'h0120, 16'h013F, 16'h011F), 4'b0000);
        addVec("idxEdge0", 2, 2'b10, pack4(16'h0400, 16'h03FF, 16'h7C00, 16'h83FF),
               pack4(16'h0210, 16'h0200, 16'h03F0, 16'h0000), 4'b0000);
        addVec("idxEdge1", 2, 2'b11, pack4(16'h0400, 16'h03FF, 16'h7C00, 16'h83FF),
               pack4(16'h0121, 16'h0120, 16'h013F, 16'h0100), 4'b0000);
        addVec("satBasic", 3, 2'b10, pack4(16'h4000, 16'hC000, 16'h0000, 16'h1000),
               pack4(16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF), 4'b0011);
        addVec("satEdge", 3, 2'b10, pack4(16'hF000, 16'h1001, 16'hFFFF, 16'h0800),
               pack4(16'h8001, 16'h7FFF, 16'hFFF8, 16'h3FFF), 4'b0010);
        addVec("identityIgnoresLut", 3, 2'b00, pack4(16'h4000, 16'hC000, 16'h8000, 16'h7FFF),
               pack4(16'h4000, 16'hC000, 16'h8000, 16'h7FFF), 4'b0000);
        addVec("reluIgnoresLut", 3, 2'b01, pack4(16'h4000, 16'hC000, 16'h8000, 16'h0001),
               pack4(16'h4000, 16'h0000, 16'h0000, 16'h0001), 4'b0000);

        repeat (3) @(posedge clk);
        #1;
        checkValue("resetOutValid", 64'(out_valid), 64'(0));
        checkValue("resetOutData", out_data, '0);
        checkValue("resetOutSat", 64'(out_sat), 64'(0));
        rst = 1'b0;
        #1;
        checkValue("resetInReady", 64'(in_ready), 64'(1));

        $display("[TB] table vectors");
        curSetup = 0;
        foreach (vecs[i]) begin
            if (vecs[i].setup != curSetup) begin
                loadSetup(vecs[i].setup);
                curSetup = vecs[i].setup;
            end
            applyStimulus(vecs[i].mode, vecs[i].data);
            checkOutput(vecs[i].name, vecs[i].expData, vecs[i].expSat, 3);
        end

        // A write on the accept edge must not reach that beat, only the next.
        $display("[TB] LUT write hazard");
        writeLut(1'b0, 32, 16'h0000, 16'h0111);
        in_valid  = 1'b1;
        in_mode   = 2'b10;
        in_data   = '0;
        lut_we    = 1'b1;
        lut_addr  = {1'b0, 6'd32};
        lut_wdata = {16'h0000, 16'h0222};
        @(posedge clk);
        #1;
        lut_we = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mode  = 2'b00;
        checkOutput("hazardOld", {4{16'h0111}}, 4'b0000, 2);
        checkOutput("hazardNew", {4{16'h0222}}, 4'b0000, 0);

        // Eight identity beats against out_ready 1,0,0 repeating; a small
        // occupancy model predicts stalls and the queue holds accepted beats.
        $display("[TB] backpressure stream");
        mV   = '0;
        sent = 0;
        rcvd = 0;
        for (int c = 0; c < 60; c++) begin
            out_ready = (c % 3 == 0);
            in_valid  = (sent < 8);
            in_mode   = 2'b00;
            in_data   = beatData(sent);
            #1;
            mStall = mV[3] && !out_ready;
            checkValue("bpInReady", 64'(in_ready), 64'(!mStall));
            checkValue("bpOutValid", 64'(out_valid), 64'(mV[3]));
            if (out_valid && out_ready) begin
                if (qExp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL bpExtraBeat: got beat %h, expected none", out_data);
                end else begin
                    checkValue("bpData", out_data, qExp.pop_front());
                    rcvd++;
                end
            end
            accept = in_valid && !mStall;
            if (accept) begin
                qExp.push_back(in_data);
            end
            @(posedge clk);
            #1;
            if (!mStall) begin
                mV = {mV[2:0], accept};
            end
            if (accept) begin
                sent++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkValue("bpDelivered", 64'(rcvd), 64'(8));
        checkValue("bpQueueEmpty", 64'(qExp.size()), 64'(0));

        // Reset lands on the edge where the first of three beats would exit.
        $display("[TB] reset with beats in flight");
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_mode  = 2'b00;
            in_data  = beatData(20 + k);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        checkValue("midResetOutValid", 64'(out_valid), 64'(0));
        checkValue("midResetOutData", out_data, '0);
        checkValue("midResetOutSat", 64'(out_sat), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkValue("postResetInReady", 64'(in_ready), 64'(1));
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) begin
                seen++;
            end
            @(posedge clk);
            #1;
        end
        checkValue("noInFlightEmerges", 64'(seen), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
